aes_out_serializer: RTL
=======================

# aes_out_serializer

- Sits directly downstream of the pipelined AES-128 core.
- Captures each 128-bit result on the core's valid pulse into a block FIFO, then emits it as four 32-bit words on a ready/valid stream.
- The AES pipeline cannot stall, so this block also runs a credit counter. The counter tells the issuing logic whether a new block may enter the core without risking FIFO overflow.

## Interface
Parameters:
- DEPTH, 16, FIFO capacity in 128-bit blocks; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of level/credit counters (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_in  in  1  pulse: a block entered the AES core this cycle (core enable)
- credit_ok  out  1  1 = outstanding < DEPTH; issuing logic may pulse issue_in
- blk_valid  in  1  AES core result valid (one cycle per block)
- blk_data  in  128  AES core result
- m_valid  out  1  output word valid
- m_data  out  32  output word
- m_last  out  1  marks fourth (final) word of a block
- m_ready  in  1  downstream accepts word
- level  out  CNT_W  blocks stored in FIFO (0..DEPTH)
- overflow  out  1  sticky error flag, cleared only by rst

## Operation
- Write: blk_valid=1 and FIFO not full → blk_data stored at tail; tail ptr +1 (wraps mod DEPTH).
- Write when full: block dropped, overflow←1, pointers unchanged.
- Word order: blk_data[127:96] first, then [95:64], [63:32], [31:0]; word index widx 0..3.
- m_valid = FIFO not empty. m_data = head entry word selected by widx; 32'h0 when empty. m_last = m_valid && widx==3.
- Word transfer when m_valid && m_ready:
  - widx +1.
  - At widx==3: widx←0, head ptr +1 (block popped).
- m_ready with m_valid=0: no effect.
- Credit counter `outstanding`, 0..DEPTH, counts blocks issued and not yet fully popped:
  - +1 on issue_in && credit_ok.
  - −1 on block pop.
  - Both in the same cycle → unchanged.
- issue_in while credit_ok=0: overflow←1, counter unchanged.
- Simultaneous write and pop when full: legal. Pop frees the slot in the same cycle, so the write is accepted; level unchanged.
- level: +1 write, −1 pop, unchanged on both or neither.
- Invariant: level ≤ outstanding. Violation (blk_valid with outstanding==0) also sets overflow, but the block is still written if space.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_last=0.
  - level=0, credit_ok=1, overflow=0.
  - widx=0, pointers=0, outstanding=0.
- Write-to-output latency: block written at edge N → m_valid=1 with word 0 after edge N (visible in cycle N+1).
- Throughput: one word per cycle with m_ready held high; 4 cycles per block. Sustained input above 1 block / 4 cycles fills the FIFO, and credit throttles issue.
- credit_ok is combinational from registered `outstanding` only; no dependence on same-cycle issue_in.
- A pop at edge N raises credit_ok in cycle N+1.
- m_data/m_last held stable while m_valid && !m_ready.
- Reset mid-block: partial block discarded, widx=0. The AES core shares rst, so no stale results arrive afterwards.

## Structure
- Shared package aes_pkg holds:
  - AES_BLK_W=128
  - AES_WORD_W=32
  - AES_WORDS_PER_BLK=4
- One sub-module, aes_blk_fifo: DEPTH×128 storage plus head/tail pointers, wrap bit for full/empty, and level.
- Word index, serialization mux, credit counter and overflow logic stay in aes_out_serializer.

## Test plan
- Single block:
  - Stimulus: reset, issue_in 1 cycle, then blk_valid with 128'h00112233_44556677_8899AABB_CCDDEEFF, m_ready=1.
  - Response: words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles; m_last on the 4th; level 1→0; credit_ok stays 1.
- Credit exhaustion:
  - Stimulus: DEPTH=16, m_ready=0, 16 issue pulses.
  - Response: credit_ok=0 after the 16th.
  - Then: a 17th issue sets overflow=1 with outstanding staying 16.
  - Then: draining 4 words restores credit_ok=1 the next cycle.
- Backpressure:
  - Stimulus: toggle m_ready 1,0,0,1 on a block.
  - Response: each word held stable while stalled; no word duplicated or skipped.
- Full FIFO with simultaneous write and pop:
  - Stimulus: 16 blocks stored; blk_valid on the same cycle the last word of the head is accepted.
  - Response: write accepted, level stays 16, overflow=0.
- Reset mid-block:
  - Stimulus: assert rst after 2 words of a block.
  - Response: all outputs at reset values immediately. A new block after reset emits from word 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath widths and word-select helper
//
// Purpose : constants shared by the AES output path, plus the function that
//           picks one 32-bit word out of a 128-bit block (MSW first).
// Ports   : none (package).
package aes_pkg;

    localparam int AES_BLK_W         = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;
    localparam int AES_WIDX_W        = $clog2(AES_WORDS_PER_BLK);

    // Word 0 is the most significant word of the block.
    function automatic logic [AES_WORD_W-1:0] aes_word_sel(
        input logic [AES_BLK_W-1:0]  blk,
        input logic [AES_WIDX_W-1:0] idx
    );
        logic [AES_WORD_W-1:0] w;
        w = blk[31:0];
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - DEPTH x 128-bit block FIFO with wrap-bit pointers
//
// Purpose : stores AES result blocks; head entry is presented combinationally.
// Ports   : clk, rst (async, active-high)
//           wr_en/wr_data   - write request; accepted if not full or if a
//                             pop happens in the same cycle
//           wr_drop         - write request was refused (FIFO full, no pop)
//           rd_en           - pop the head entry (ignored when empty)
//           rd_data         - head entry
//           full, empty     - status from registered pointers
//           level           - stored blocks, 0..DEPTH
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AES_BLK_W-1:0] wr_data,
    output logic                 wr_drop,
    input  logic                 rd_en,
    output logic [AES_BLK_W-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     level
);

    localparam int PTR_W = CNT_W - 1;

    logic [CNT_W-1:0]     head_q, head_d;
    logic [CNT_W-1:0]     tail_q, tail_d;
    logic [AES_BLK_W-1:0] mem_q [DEPTH];
    logic                 wr_acc;
    logic                 rd_acc;

    // Top bit of each pointer is the wrap bit: equal indices with differing
    // wrap bits means full, fully equal means empty.
    assign empty   = (tail_q == head_q);
    assign full    = (tail_q[PTR_W-1:0] == head_q[PTR_W-1:0]) &&
                     (tail_q[PTR_W] != head_q[PTR_W]);
    assign level   = tail_q - head_q;
    assign rd_data = mem_q[head_q[PTR_W-1:0]];

    always_comb begin
        rd_acc  = rd_en && !empty;
        // A same-cycle pop frees the slot, so a write into a full FIFO is fine.
        wr_acc  = wr_en && (!full || rd_acc);
        wr_drop = wr_en && !wr_acc;
        head_d  = head_q + CNT_W'(rd_acc);
        tail_d  = tail_q + CNT_W'(wr_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[tail_q[PTR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - AES block capture, 4-word serializer and issue credit
//
// Purpose : buffers AES-128 results and streams them as 32-bit words, MSW
//           first; tracks blocks in flight so the issuer never overruns the
//           FIFO (the AES pipeline cannot stall).
// Ports   : clk, rst (async, active-high)
//           issue_in, credit_ok        - issue pulse in / permission out
//           blk_valid, blk_data        - AES core result
//           m_valid, m_data, m_last, m_ready - word stream out
//           level                      - blocks held in the FIFO
//           overflow                   - sticky error flag
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_in,
    output logic                  credit_ok,
    input  logic                  blk_valid,
    input  logic [AES_BLK_W-1:0]  blk_data,
    output logic                  m_valid,
    output logic [AES_WORD_W-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      level,
    output logic                  overflow
);

    logic [AES_WIDX_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  overflow_q, overflow_d;

    logic [AES_BLK_W-1:0]  head_blk;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_drop;
    logic                  xfer;
    logic                  pop;
    logic                  issue_acc;

    aes_blk_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (blk_valid),
        .wr_data (blk_data),
        .wr_drop (wr_drop),
        .rd_en   (pop),
        .rd_data (head_blk),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Credit depends only on registered state so the issuer sees no comb loop.
    assign credit_ok = (outstanding_q < CNT_W'(DEPTH));
    assign overflow  = overflow_q;

    always_comb begin
        m_valid   = !fifo_empty;
        m_data    = m_valid ? aes_word_sel(head_blk, widx_q) : '0;
        m_last    = m_valid && (widx_q == AES_WIDX_W'(AES_WORDS_PER_BLK - 1));
        xfer      = m_valid && m_ready;
        pop       = xfer && m_last;
        issue_acc = issue_in && credit_ok;

        widx_d = widx_q;
        if (xfer) begin
            widx_d = widx_q + AES_WIDX_W'(1);
        end

        outstanding_d = outstanding_q;
        if (issue_acc && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!issue_acc && pop && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        // Refused issue, dropped block, or a result nobody issued.
        overflow_d = overflow_q
                   | (issue_in && !credit_ok)
                   | wr_drop
                   | (blk_valid && (outstanding_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q        <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            widx_q        <= widx_d;
            outstanding_q <= outstanding_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule
